mux_n_skid: RTL and testbench

- Parametrised N-input, WIDTH-bit selector with a registered output stage and a 2-entry skid buffer.
- Full valid/ready handshake on both sides.
- Used in pipeline stages where the selected operand must be held across downstream stalls without a combinational ready path from out_ready to in_ready.
- Supports a synchronous flush for branch/exception squash and flags out-of-range selects.

---
 rtl/mux_n_skid.sv | 129 ++++++++++++
 tb/tb_mux_n_skid.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_skid.sv
`default_nettype none
// ============================================================================
// Module      : mux_n_skid
// Description : N-input WIDTH-bit selector with a registered head stage and a
//               second skid entry; valid/ready on both sides, registered
//               in_ready, synchronous flush and out-of-range select flagging.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_n_skid #(
    parameter int WIDTH    = 32,
    parameter int N_IN     = 4,
    parameter int SEL_W    = $clog2(N_IN),
    parameter int OOR_ZERO = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam bit c_full_range = (N_IN == (1 << SEL_W));

    logic [WIDTH-1:0] w_sel_data;
    logic             w_hit;
    logic             w_sel_err;
    logic             w_accept;
    logic             w_emit;

    logic [WIDTH-1:0] r_main_data;
    logic [SEL_W-1:0] r_main_sel;
    logic             r_main_err;
    logic             r_main_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic [SEL_W-1:0] r_skid_sel;
    logic             r_skid_err;
    logic             r_skid_valid;
    logic             r_in_ready;

    always_comb begin
        w_sel_data = (OOR_ZERO != 0) ? '0 : in_data[WIDTH-1:0];
        w_hit      = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                w_sel_data = in_data[k*WIDTH +: WIDTH];
                w_hit      = 1'b1;
            end
        end
    end

    // Every encoding is a legal input when N_IN fills the select range.
    assign w_sel_err = c_full_range ? 1'b0 : !w_hit;
    assign w_accept  = in_valid && r_in_ready;
    assign w_emit    = r_main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_data  <= '0;
            r_main_sel   <= '0;
            r_main_err   <= 1'b0;
            r_main_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_sel   <= '0;
            r_skid_err   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            // Payload registers keep their contents; only occupancy clears.
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            case ({r_main_valid, r_skid_valid})
                2'b00: begin
                    if (w_accept) begin
                        r_main_data  <= w_sel_data;
                        r_main_sel   <= sel;
                        r_main_err   <= w_sel_err;
                        r_main_valid <= 1'b1;
                    end
                end
                2'b10: begin
                    if (w_accept && w_emit) begin
                        r_main_data <= w_sel_data;
                        r_main_sel  <= sel;
                        r_main_err  <= w_sel_err;
                    end else if (w_accept) begin
                        r_skid_data  <= w_sel_data;
                        r_skid_sel   <= sel;
                        r_skid_err   <= w_sel_err;
                        r_skid_valid <= 1'b1;
                        r_in_ready   <= 1'b0;
                    end else if (w_emit) begin
                        r_main_valid <= 1'b0;
                    end
                end
                2'b11: begin
                    if (w_emit) begin
                        r_main_data  <= r_skid_data;
                        r_main_sel   <= r_skid_sel;
                        r_main_err   <= r_skid_err;
                        r_skid_valid <= 1'b0;
                        r_in_ready   <= 1'b1;
                    end
                end
                default: begin
                    r_main_valid <= 1'b0;
                    r_skid_valid <= 1'b0;
                    r_in_ready   <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_data  = r_main_data;
    assign out_sel   = r_main_sel;
    assign out_err   = r_main_err;
    assign out_valid = r_main_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_n_skid.sv
`default_nettype none
// Testbench for mux_n_skid: three instances (N=4; N=3 zeroing; N=3 input-0)
// share stimulus and are checked against a queue model every cycle.
module tb_mux_n_skid;

    localparam logic [31:0] c_a = 32'hAAAA0000;
    localparam logic [31:0] c_b = 32'hBBBB0001;
    localparam logic [31:0] c_c = 32'hCCCC0002;
    localparam logic [31:0] c_d = 32'hDDDD0003;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] in_data = {c_d, c_c, c_b, c_a};
    logic [1:0]   sel = '0;
    logic         in_valid = 1'b0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b0;

    logic [31:0] od [3];
    logic [1:0]  os [3];
    logic        oe [3];
    logic        ov [3];
    logic        ir [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_n_skid #(.WIDTH(32), .N_IN(4), .OOR_ZERO(1)) u_dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
        .in_ready(ir[0]), .flush(flush), .out_data(od[0]), .out_sel(os[0]),
        .out_err(oe[0]), .out_valid(ov[0]), .out_ready(out_ready));

    mux_n_skid #(.WIDTH(32), .N_IN(3), .OOR_ZERO(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in_data[95:0]), .sel(sel), .in_valid(in_valid),
        .in_ready(ir[1]), .flush(flush), .out_data(od[1]), .out_sel(os[1]),
        .out_err(oe[1]), .out_valid(ov[1]), .out_ready(out_ready));

    mux_n_skid #(.WIDTH(32), .N_IN(3), .OOR_ZERO(0)) u_dut2 (
        .clk(clk), .rst(rst), .in_data(in_data[95:0]), .sel(sel), .in_valid(in_valid),
        .in_ready(ir[2]), .flush(flush), .out_data(od[2]), .out_sel(os[2]),
        .out_err(oe[2]), .out_valid(ov[2]), .out_ready(out_ready));

    // ---------------- model: FIFO of at most two entries per instance ----
    typedef struct {
        logic [31:0] d;
        logic [1:0]  s;
        logic        e;
    } ent_t;

    ent_t mq [3][$];
    ent_t mlast [3];
    logic m_ready = 1'b1;
    bit   live = 1'b0;

    function automatic ent_t pick(int inst, logic [127:0] data, logic [1:0] s);
        ent_t r;
        int   n;
        n   = (inst == 0) ? 4 : 3;
        r.s = s;
        r.e = (int'(s) >= n);
        if (int'(s) < n)   r.d = data[32*int'(s) +: 32];
        else if (inst == 2) r.d = data[31:0];
        else               r.d = 32'h0;
        return r;
    endfunction

    always @(posedge clk) begin
        bit acc, emit;
        if (rst) begin
            live    = 1'b1;
            m_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                mq[i].delete();
                mlast[i] = '{d: 32'h0, s: 2'd0, e: 1'b0};
            end
        end else if (live) begin
            acc = in_valid && m_ready;
            for (int i = 0; i < 3; i++) begin
                emit = (mq[i].size() > 0) && out_ready;
                if (emit) void'(mq[i].pop_front());
                if (acc && !flush) mq[i].push_back(pick(i, in_data, sel));
                if (flush) mq[i].delete();
                if (mq[i].size() > 0) mlast[i] = mq[i][0];
            end
            m_ready = (mq[0].size() < 2);
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model out_valid[%0d]", i), 32'(ov[i]), 32'(mq[i].size() > 0));
                chk($sformatf("model in_ready[%0d]", i), 32'(ir[i]), 32'(m_ready));
                chk($sformatf("model out_data[%0d]", i), od[i], mlast[i].d);
                chk($sformatf("model out_sel[%0d]", i), 32'(os[i]), 32'(mlast[i].s));
                chk($sformatf("model out_err[%0d]", i), 32'(oe[i]), 32'(mlast[i].e));
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------
    task automatic cyc(logic v, logic [1:0] s, logic ordy, logic fl = 1'b0, logic r = 1'b0);
        in_valid  = v;
        sel       = s;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(1'b1, 2'd1, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 2'd0, 1'b0);
        chk("reset out_valid", 32'(ov[0]), 32'd0);
        chk("reset in_ready", 32'(ir[0]), 32'd1);
        chk("reset out_data", od[0], 32'h0);
        chk("reset out_sel/err", {os[0], oe[0]}, 32'd0);

        // stream with out_ready=1
        cyc(1'b1, 2'd0, 1'b1); chk("stream A", od[0], c_a);
        cyc(1'b1, 2'd1, 1'b1); chk("stream B", od[0], c_b);
        cyc(1'b1, 2'd2, 1'b1); chk("stream C", od[0], c_c);
        cyc(1'b1, 2'd3, 1'b1); chk("stream D", od[0], c_d);
        chk("stream in_ready", 32'(ir[0]), 32'd1);
        chk("stream out_valid", 32'(ov[0]), 32'd1);
        cyc(1'b0, 2'd0, 1'b1); chk("stream drained", 32'(ov[0]), 32'd0);

        // backpressure
        cyc(1'b1, 2'd1, 1'b0); chk("bp main B", od[0], c_b);
        cyc(1'b1, 2'd2, 1'b0); chk("bp in_ready low", 32'(ir[0]), 32'd0);
        cyc(1'b1, 2'd3, 1'b0); chk("bp holds B", od[0], c_b);
        cyc(1'b1, 2'd3, 1'b1); chk("bp emits C next", od[0], c_c);
        chk("bp in_ready back", 32'(ir[0]), 32'd1);
        cyc(1'b1, 2'd3, 1'b1); chk("bp then D", od[0], c_d);
        cyc(1'b0, 2'd0, 1'b1); chk("bp drained", 32'(ov[0]), 32'd0);

        // accept+emit every cycle in ONE
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 2'(i % 4), 1'b1);
            chk("one-state in_ready", 32'(ir[0]), 32'd1);
        end
        cyc(1'b0, 2'd0, 1'b1);

        // flush while FULL with a concurrent sel=0 offer
        cyc(1'b1, 2'd1, 1'b0);
        cyc(1'b1, 2'd2, 1'b0);
        cyc(1'b1, 2'd0, 1'b0, 1'b1);
        chk("flush out_valid", 32'(ov[0]), 32'd0);
        chk("flush in_ready", 32'(ir[0]), 32'd1);
        chk("flush retains data", od[0], c_b);
        cyc(1'b0, 2'd0, 1'b1);
        cyc(1'b0, 2'd0, 1'b1);
        chk("flush nothing emerges", 32'(ov[0]), 32'd0);

        // out-of-range select on the N_IN=3 instances
        cyc(1'b1, 2'd3, 1'b1);
        chk("oor zero data", od[1], 32'h0);
        chk("oor zero err", 32'(oe[1]), 32'd1);
        chk("oor zero sel", 32'(os[1]), 32'd3);
        chk("oor in0 data", od[2], c_a);
        chk("oor in0 err", 32'(oe[2]), 32'd1);
        chk("n4 sel3 data", od[0], c_d);
        chk("n4 sel3 err", 32'(oe[0]), 32'd0);
        cyc(1'b0, 2'd0, 1'b1);

        // reset while FULL together with flush and in_valid
        cyc(1'b1, 2'd1, 1'b0);
        cyc(1'b1, 2'd2, 1'b0);
        cyc(1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
        chk("midrst out_valid", 32'(ov[0]), 32'd0);
        chk("midrst in_ready", 32'(ir[0]), 32'd1);
        chk("midrst out_data", od[0], 32'h0);
        chk("midrst sel/err", {os[0], oe[0]}, 32'd0);
        cyc(1'b1, 2'd2, 1'b1);
        chk("post-reset C", od[0], c_c);
        chk("post-reset valid", 32'(ov[0]), 32'd1);
        cyc(1'b0, 2'd0, 1'b1);

        // mixed traffic checked by the model only
        for (int i = 0; i < 300; i++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end
        cyc(1'b0, 2'd0, 1'b1);
        cyc(1'b0, 2'd0, 1'b1);
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
